// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight, and holds the fetched word for decode.
// Optional IFETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets a sticky flag and halts fetch until reset.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        req_valid_q, req_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] target;
    logic        trap;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misaligned_q, misaligned_d;

    assign target     = redirect_target;
    assign trap       = redirect && (redirect_target[1:0] != 2'b00);
    assign misaligned = misaligned_q;
`else
    assign target     = redirect_target & 32'hFFFF_FFFC;
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    fetch_pc_d = target;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    // An accepted request to the old address must have its response discarded.
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d = imem_rsp_data;
                        pc_d    = fetch_pc_q;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    instr_d    = NOP_INSTR;
                    state_d    = REQ;
                end else if (instr_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = REQ;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (trap && (state_q != HALT)) begin
            state_d = HALT;
            drop_d  = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misaligned_d = 1'b1;
`endif
        end

        // Handshake outputs are registered copies of the next state.
        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misaligned_q  <= misaligned_d;
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign op             = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[30];

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios followed by random traffic, checked against a
// transaction-level model (expected next fetch address, flat memory contents, one-outstanding memory).
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        misaligned;

    ifetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    bit          outstanding = 1'b0;
    int unsigned cnt = 0;
    int unsigned lat = 1;
    logic [31:0] out_addr = '0;

    logic [31:0] exp_pc = '0;
    bit          halted = 1'b0;
    int unsigned deliveries = 0;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0003;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: called and returns at a negedge, with inputs for the coming edge already set.
    task automatic step();
        logic        acc, fire, cons, redir, pv, pready;
        logic [31:0] tgt, addr_s, pinstr, ppc, raw;
        logic [31:0] d;
        acc    = imem_req_valid && imem_req_ready;
        fire   = imem_rsp_valid;
        cons   = instr_valid && instr_ready;
        redir  = redirect;
        raw    = redirect_target;
        tgt    = redirect_target & 32'hFFFF_FFFC;
        addr_s = imem_addr;
        pv     = instr_valid;
        pready = instr_ready;
        pinstr = instr;
        ppc    = pc;
        chk("one_outstanding", 32'(acc && outstanding && !fire), 32'h0);
        @(posedge clk);
        if (fire) outstanding = 1'b0;
        else if (outstanding && cnt > 1) cnt--;
        if (acc) begin
            outstanding = 1'b1;
            cnt         = lat;
            out_addr    = addr_s;
        end
        if (!halted) begin
            if (redir && TRAP && raw[1:0] != 2'b00) halted = 1'b1;
            else if (redir) exp_pc = tgt;
            else if (cons) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
        end
        @(negedge clk);
        imem_rsp_valid = outstanding && cnt == 1;
        imem_rsp_data  = outstanding ? memdata(out_addr) : $urandom();
        chk("misaligned", 32'(misaligned), 32'(halted));
        chk("req_and_valid", 32'(imem_req_valid && instr_valid), 32'h0);
        if (halted) begin
            chk("halt_req", 32'(imem_req_valid), 32'h0);
            chk("halt_valid", 32'(instr_valid), 32'h0);
        end else begin
            if (pv && !pready && !redir) begin
                chk("stable_valid", 32'(instr_valid), 32'h1);
                chk("stable_instr", instr, pinstr);
                chk("stable_pc", pc, ppc);
            end
            if (imem_req_valid) chk("imem_addr", imem_addr, exp_pc);
            if (instr_valid) begin
                d = memdata(exp_pc);
                chk("pc", pc, exp_pc);
                chk("instr", instr, d);
                chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
                chk("op", 32'(op), 32'(d[6:0]));
                chk("funct3", 32'(funct3), 32'(d[14:12]));
                chk("funct7", 32'(funct7), 32'(d[30]));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'h0);
    endtask

    // Asserts reset with a stray response on the bus, then releases and takes the first edge.
    task automatic do_reset();
        rst             = 1'b1;
        redirect        = 1'b0;
        instr_ready     = 1'b0;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'hDEAD_BEEF;
        #1;
        check_reset_values("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_reset_values("rst_held");
        imem_rsp_valid = 1'b0;
        outstanding    = 1'b0;
        cnt            = 0;
        exp_pc         = '0;
        halted         = 1'b0;
        rst            = 1'b0;
        step();
        chk("first_req_valid", 32'(imem_req_valid), 32'h1);
        chk("first_req_addr", imem_addr, 32'h0);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        chk(tag, 32'(imem_req_valid), 32'h1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk(tag, 32'(instr_valid), 32'h1);
    endtask

    initial begin
        @(negedge clk);
        imem_req_ready = 1'b1;
        lat = 1;
        do_reset();

        step();
        step();
        chk("t1_valid", 32'(instr_valid), 32'h1);
        chk("t1_op", 32'(op), 32'h03);
        chk("t1_pc_plus4", pc_plus4, 32'h4);

        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", 32'(instr_valid), 32'h1);
            chk("t2_no_req", 32'(imem_req_valid), 32'h0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t2_next_req", 32'(imem_req_valid), 32'h1);
        chk("t2_next_addr", imem_addr, 32'h4);

        step();
        step();
        chk("t3_valid", 32'(instr_valid), 32'h1);
        redirect        = 1'b1;
        redirect_target = 32'h40;
        instr_ready     = 1'b1;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("t3_valid_drop", 32'(instr_valid), 32'h0);
        chk("t3_nop", instr, NOP);
        chk("t3_req", 32'(imem_req_valid), 32'h1);
        chk("t3_addr", imem_addr, 32'h40);

        lat = 3;
        step();
        chk("t4_in_wait", 32'(imem_req_valid), 32'h0);
        redirect        = 1'b1;
        redirect_target = 32'h80;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 10 && !imem_req_valid; i++) begin
            chk("t4_no_valid", 32'(instr_valid), 32'h0);
            step();
        end
        chk("t4_reissue", 32'(imem_req_valid), 32'h1);
        chk("t4_addr", imem_addr, 32'h80);

        lat = 1;
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_valid("t5_valid");
        chk("t5_pc", pc, 32'hFFFF_FFFC);
        chk("t5_pc_plus4", pc_plus4, 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t5_wrap_req", 32'(imem_req_valid), 32'h1);
        chk("t5_wrap_addr", imem_addr, 32'h0);

        redirect        = 1'b1;
        redirect_target = 32'h102;
        step();
        redirect = 1'b0;
        if (TRAP) begin
            chk("t6_misaligned", 32'(misaligned), 32'h1);
            for (int i = 0; i < 10; i++) begin
                step();
                chk("t6_halt_no_req", 32'(imem_req_valid), 32'h0);
            end
        end else begin
            wait_req("t6_req");
            chk("t6_addr", imem_addr, 32'h100);
            chk("t6_misaligned", 32'(misaligned), 32'h0);
        end

        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [31:0] t;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 4);
            instr_ready    = $urandom_range(0, 1) == 1;
            redirect       = ($urandom_range(0, 11) == 0);
            t              = $urandom();
            if (TRAP) t[1:0] = 2'b00;
            redirect_target = t;
            step();
            if (i == 400) do_reset();
        end
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("progress", 32'(deliveries >= 20), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
